// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, NZCV flag bit positions and condition codes.
// Pure declarations; no timing or backpressure of its own.
// Used by the writeback stage, the condition evaluator and decode.
package alu_pkg;

    localparam int DATA_W_DEF = 21;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

endpackage

// File: rtl/cond_eval.sv
// Evaluates a 4-bit condition code against an NZCV flag vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       cond_pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_pass = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c & !z;
            COND_LS: cond_pass = !c | z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z & (n == v);
            COND_LE: cond_pass = z | (n != v);
            COND_AL: cond_pass = 1'b1;
            COND_NV: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU-to-writeback stage: two-entry skid FIFO of {result, rd, wen} plus the architectural NZCV register.
// Latency: a beat accepted into an empty stage is presented on out_* the next cycle.
// Backpressure: in_ready comes only from the registered occupancy, so out_ready never reaches in_ready combinationally.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flags,
    input  logic              in_setflags,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wen,
    output logic [3:0]        flags,
    input  logic [3:0]        cond,
    output logic              cond_pass
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
        logic              wen;
    } beat_t;

    beat_t       mem [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic [3:0]  flags_q;
    logic        accept;
    logic        pop;
    beat_t       in_beat;

    assign in_beat = '{result: in_result, rd: in_rd, wen: in_wen};

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_result = mem[head].result;
    assign out_rd     = mem[head].rd;
    // An empty stage never advertises a register write, even with stale slot contents.
    assign out_wen    = mem[head].wen & out_valid;
    assign flags      = flags_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            head    <= 1'b0;
            tail    <= 1'b0;
            count   <= 2'd0;
            flags_q <= 4'b0000;
        end else begin
            if (accept) begin
                mem[tail] <= in_beat;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (accept && in_setflags) begin
                flags_q <= in_flags;
            end
        end
    end

    cond_eval u_cond_eval (
        .flags     (flags_q),
        .cond      (cond),
        .cond_pass (cond_pass)
    );

endmodule

// File: tb/tb_alu_wb_stage.sv
// Randomized + directed bench for alu_wb_stage: a scoreboard queue holds accepted beats,
// a separate monitor pops and compares on every delivered beat and checks status each cycle.
module tb_alu_wb_stage;

    localparam int DW = 21;
    localparam int RW = 4;

    typedef struct packed {
        logic [DW-1:0] r;
        logic [RW-1:0] rd;
        logic          wen;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_result = '0;
    logic [3:0]    in_flags = '0;
    logic          in_setflags = 1'b0;
    logic [RW-1:0] in_rd = '0;
    logic          in_wen = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_rd;
    logic          out_wen;
    logic [3:0]    flags;
    logic [3:0]    cond = '0;
    logic          cond_pass;

    beat_t      sb[$];
    logic [3:0] mflags = 4'b0000;
    int         checks = 0;
    int         failures = 0;
    int         delivered = 0;

    alu_wb_stage #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_flags    (in_flags),
        .in_setflags (in_setflags),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .flags       (flags),
        .cond        (cond),
        .cond_pass   (cond_pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference condition evaluation straight from the architectural definitions.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  r = z;
            4'd1:  r = !z;
            4'd2:  r = cy;
            4'd3:  r = !cy;
            4'd4:  r = n;
            4'd5:  r = !n;
            4'd6:  r = v;
            4'd7:  r = !v;
            4'd8:  r = cy && !z;
            4'd9:  r = !cy || z;
            4'd10: r = (n == v);
            4'd11: r = (n != v);
            4'd12: r = !z && (n == v);
            4'd13: r = z || (n != v);
            4'd14: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // One cycle of stimulus; the accepted beat (if any) goes to the scoreboard.
    task automatic drive(input logic v, input logic [DW-1:0] res, input logic [RW-1:0] rd,
                         input logic wen, input logic [3:0] fl, input logic sf,
                         input logic ordy, input logic [3:0] cnd);
        @(negedge clk);
        in_valid = v; in_result = res; in_rd = rd; in_wen = wen;
        in_flags = fl; in_setflags = sf; out_ready = ordy; cond = cnd;
        #2;
        if (in_valid && in_ready) begin
            sb.push_back('{r: res, rd: rd, wen: wen});
            if (sf) mflags = fl;
        end
    endtask

    task automatic idle(input logic ordy, input logic [3:0] cnd);
        drive(1'b0, '0, '0, 1'b0, 4'h0, 1'b0, ordy, cnd);
    endtask

    // Monitor: per-cycle status checks and in-order delivery checking.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("in_ready", in_ready, (sb.size() < 2));
                chk("out_valid", out_valid, (sb.size() != 0));
                chk("flags", flags, mflags);
                chk("cond_pass", cond_pass, ref_cond(mflags, cond));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_result", out_result, e.r);
                        chk("out_rd", out_rd, e.rd);
                        chk("out_wen", out_wen, e.wen);
                        delivered++;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int d0;
        // Power-on reset.
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", flags, 0);
        chk("rst_out_wen", out_wen, 0);

        // Single beat, immediate drain.
        drive(1'b1, 21'h00005, 4'd3, 1'b1, 4'h0, 1'b0, 1'b1, 4'd14);
        idle(1'b1, 4'd14);
        idle(1'b1, 4'd14);
        chk("single_drained", sb.size(), 0);

        // Fill with A,B under stall; C held off until a slot frees.
        drive(1'b1, 21'h0000A, 4'd1, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 21'h0000B, 4'd2, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 21'h0000C, 4'd4, 1'b1, 4'h0, 1'b0, 1'b0, 4'd0);
        chk("full_c_blocked", sb.size(), 2);
        drive(1'b1, 21'h0000C, 4'd4, 1'b1, 4'h0, 1'b0, 1'b1, 4'd0);
        drive(1'b1, 21'h0000C, 4'd4, 1'b1, 4'h0, 1'b0, 1'b1, 4'd0);
        repeat (3) idle(1'b1, 4'd0);
        chk("abc_delivered", delivered, 4);

        // Flag load visibility, then a beat that must not touch flags.
        drive(1'b1, 21'h00011, 4'd5, 1'b1, 4'b0100, 1'b1, 1'b1, 4'd0);
        chk("eq_accept_cycle", cond_pass, 0);
        drive(1'b1, 21'h00012, 4'd6, 1'b1, 4'b0000, 1'b0, 1'b1, 4'd0);
        chk("eq_next_cycle", cond_pass, 1);
        idle(1'b1, 4'd0);
        chk("flags_held", flags, 4'b0100);

        // N=1,V=1: sweep every condition code.
        drive(1'b1, 21'h00013, 4'd7, 1'b0, 4'b1001, 1'b1, 1'b1, 4'd0);
        for (int c = 0; c < 16; c++) idle(1'b1, c[3:0]);
        chk("sweep_flags", flags, 4'b1001);

        // Steady state at occupancy 1 with accept and pop every cycle.
        drive(1'b1, 21'h00100, 4'd8, 1'b1, 4'h0, 1'b0, 1'b0, 4'd14);
        d0 = delivered;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(21'h00200 + i), 4'(i), 1'b1, 4'h0, 1'b0, 1'b1, 4'd14);
            chk("steady_ready", in_ready, 1);
            chk("steady_occ", sb.size(), 1);
        end
        chk("steady_count", delivered - d0, 10);
        idle(1'b1, 4'd14);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, DW'($urandom), RW'($urandom), $urandom_range(0, 1) == 1,
                  4'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, 4'($urandom));
        end

        // Asynchronous reset with the FIFO full and all flags set.
        idle(1'b1, 4'd0);
        idle(1'b1, 4'd0);
        drive(1'b1, 21'h0AAAA, 4'd9, 1'b1, 4'b1111, 1'b1, 1'b0, 4'd14);
        drive(1'b1, 21'h0BBBB, 4'd10, 1'b1, 4'b1111, 1'b1, 1'b0, 4'd14);
        chk("pre_rst_full", sb.size(), 2);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_flags", flags, 0);
        chk("arst_out_wen", out_wen, 0);
        sb.delete();
        mflags = 4'b0000;
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);
        drive(1'b1, 21'h1CAFE, 4'd11, 1'b1, 4'h0, 1'b0, 1'b1, 4'd14);
        idle(1'b1, 4'd14);
        chk("post_rst_drained", sb.size(), 0);

        // Bounded final drain.
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1, 4'd14);
        chk("final_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 Parameter: DATA_W, default 21, result width; matches the ALU datapath.
REQ-002 Parameter: RD_W, default 4, destination-register index width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  ALU beat present.
REQ-006 Port: in_ready  output  1  stage can accept a beat this cycle.
REQ-007 Port: in_result  input  DATA_W  ALU Result.
REQ-008 Port: in_flags  input  4  ALU flags {Negative, Zero, Carry, OverFlow} (bit 3..0 = N,Z,C,V).
REQ-009 Port: in_setflags  input  1  beat updates the architectural flags.
REQ-010 Port: in_rd / in_wen  input  RD_W / 1  destination index, register-write enable.
REQ-011 Port: out_valid  output  1  head beat available to writeback.
REQ-012 Port: out_ready  input  1  writeback consumes head beat.
REQ-013 Port: out_result / out_rd / out_wen  output  DATA_W / RD_W / 1  head beat fields.
REQ-014 Port: flags  output  4  architectural NZCV register.
REQ-015 Port: cond  input  4  condition code to evaluate.
REQ-016 Port: cond_pass  output  1  cond evaluated against flags register, combinational.

Function
REQ-017 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 Two-entry FIFO (skid buffer) of {result, rd, wen}; head/tail pointers wrap modulo 2; count 0..2.
REQ-019 in_ready = (count < 2), driven from registered count only; no combinational path from out_ready.
REQ-020 out_valid = (count != 0); out_* show head entry; held stable while out_valid & !out_ready.
REQ-021 Latency: beat accepted in cycle n with count 0 appears on out_* in cycle n+1.
REQ-022 Accept and pop same cycle with count 1: count stays 1, head advances to accepted beat.
REQ-023 Full (count 2): in_ready 0, in_valid ignored, no overwrite; pop frees one slot, in_ready 1 next cycle.
REQ-024 Pop with count 0 impossible (out_valid 0); out_ready ignored.
REQ-025 Flags register loads in_flags at the clock edge of an accept with in_setflags 1; otherwise holds; independent of out_ready/FIFO drain.
REQ-026 cond_pass mapping (0..15): EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; NV 0.
REQ-027 cond_pass reflects flags register value (pre-update) in the accept cycle; new flags visible the following cycle.
REQ-028 Beats with in_wen 0 still occupy a slot and are delivered in order.

Reset
REQ-029 rst asserted: count 0, pointers 0, flags 4'b0000 immediately (asynchronous), out_valid 0, in_ready 1 after release.
REQ-030 Reset mid-operation discards all buffered beats; no partial flag update; out_* data values after reset don't-care, out_wen 0.

Structure
REQ-031 Shared package alu_pkg: DATA_W default, flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), 4-bit condition-code enum with the 16 codes of REQ-026.
REQ-032 One sub-module: cond_eval (flags, cond -> cond_pass), purely combinational, also reused by decode.

Verification
REQ-033 Reset then single beat result 21'h00005, rd 3, wen 1, out_ready 1 -> out_valid 1 next cycle, out_result 21'h00005, out_rd 3, count back to 0.
REQ-034 out_ready 0, three consecutive in_valid beats A,B,C -> A,B accepted, in_ready 0 in cycle 2, C held; raise out_ready -> A,B,C delivered in order, none lost or duplicated.
REQ-035 Accept in_flags 4'b0100, setflags 1, cond EQ -> cond_pass 0 in accept cycle, 1 next cycle; next beat setflags 0 flags 4'b0000 -> flags stay 4'b0100.
REQ-036 flags 4'b1001 (N=1,V=1): sweep cond 0..15 -> GE 1, LT 0, GT 1, LE 0, MI 1, VS 1, AL 1, NV 0.
REQ-037 Count 1, simultaneous accept and pop for 10 cycles -> count stays 1, in_ready 1 throughout, output stream equals input stream delayed one cycle.
REQ-038 Assert rst with count 2 and flags 4'b1111 -> out_valid 0 and flags 0 before next clock edge; post-reset first beat delivered normally.
